// File: rtl/y86_pipe_stage_reg.sv
// Parametrised Y86-64 inter-stage pipeline register with stall/bubble hazard
// control, a valid flag, saturating event counters and a stall watchdog.
module y86_pipe_stage_reg #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NVAL      = 5,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8,
  parameter logic [3:0]  BUB_ICODE = 4'h1,
  parameter logic [2:0]  BUB_STAT  = 3'b001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   bubble,
  input  logic [2:0]             in_stat,
  input  logic [3:0]             in_icode,
  input  logic [3:0]             in_rA,
  input  logic [3:0]             in_rB,
  input  logic [NVAL*WORD_W-1:0] in_vals,
  input  logic                   in_cnd,
  output logic [2:0]             out_stat,
  output logic [3:0]             out_icode,
  output logic [3:0]             out_rA,
  output logic [3:0]             out_rB,
  output logic [NVAL*WORD_W-1:0] out_vals,
  output logic                   out_cnd,
  output logic                   out_valid,
  output logic                   ctl_conflict,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt,
  output logic                   stall_timeout
);

  localparam logic [3:0] RNONE = 4'hF;

  logic [CNT_W-1:0] stall_run;
  logic [CNT_W-1:0] stall_run_next;
  logic             do_stall;

  // Bubble overrides stall, so only a stall without bubble counts as a hold.
  assign do_stall = stall & ~bubble;

  always_comb begin
    stall_run_next = '0;
    if (do_stall) begin
      stall_run_next = (stall_run == '1) ? stall_run : stall_run + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_stat      <= BUB_STAT;
      out_icode     <= BUB_ICODE;
      out_rA        <= RNONE;
      out_rB        <= RNONE;
      out_vals      <= '0;
      out_cnd       <= 1'b0;
      out_valid     <= 1'b0;
      ctl_conflict  <= 1'b0;
      stall_cnt     <= '0;
      bubble_cnt    <= '0;
      stall_run     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      ctl_conflict <= stall & bubble;
      stall_run    <= stall_run_next;
      if (stall_run_next >= CNT_W'(MAX_STALL)) begin
        stall_timeout <= 1'b1;
      end

      if (bubble) begin
        out_stat  <= BUB_STAT;
        out_icode <= BUB_ICODE;
        out_rA    <= RNONE;
        out_rB    <= RNONE;
        out_vals  <= '0;
        out_cnd   <= 1'b0;
        out_valid <= 1'b0;
        if (bubble_cnt != '1) begin
          bubble_cnt <= bubble_cnt + 1'b1;
        end
      end else if (stall) begin
        if (stall_cnt != '1) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        out_stat  <= in_stat;
        out_icode <= in_icode;
        out_rA    <= in_rA;
        out_rB    <= in_rB;
        out_vals  <= in_vals;
        out_cnd   <= in_cnd;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// Directed self-checking bench for y86_pipe_stage_reg: a default instance plus
// a narrow-counter instance sharing the same stimulus.
module tb_y86_pipe_stage_reg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned NVAL   = 5;
  localparam int unsigned VW     = NVAL * WORD_W;

  logic          clk = 1'b0;
  logic          rst, stall, bubble, in_cnd;
  logic [2:0]    in_stat;
  logic [3:0]    in_icode, in_rA, in_rB;
  logic [VW-1:0] in_vals;

  logic [2:0]    out_stat, out_stat2;
  logic [3:0]    out_icode, out_rA, out_rB, out_icode2, out_rA2, out_rB2;
  logic [VW-1:0] out_vals, out_vals2;
  logic          out_cnd, out_valid, ctl_conflict, stall_timeout;
  logic          out_cnd2, out_valid2, ctl_conflict2, stall_timeout2;
  logic [15:0]   stall_cnt, bubble_cnt;
  logic [2:0]    stall_cnt2, bubble_cnt2;

  int checks = 0;
  int failures = 0;

  logic [VW-1:0] vals_a;

  always #5 clk = ~clk;

  y86_pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
    .in_vals(in_vals), .in_cnd(in_cnd),
    .out_stat(out_stat), .out_icode(out_icode), .out_rA(out_rA), .out_rB(out_rB),
    .out_vals(out_vals), .out_cnd(out_cnd), .out_valid(out_valid),
    .ctl_conflict(ctl_conflict), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .stall_timeout(stall_timeout)
  );

  y86_pipe_stage_reg #(.CNT_W(3), .MAX_STALL(5)) dut_narrow (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
    .in_vals(in_vals), .in_cnd(in_cnd),
    .out_stat(out_stat2), .out_icode(out_icode2), .out_rA(out_rA2), .out_rB(out_rB2),
    .out_vals(out_vals2), .out_cnd(out_cnd2), .out_valid(out_valid2),
    .ctl_conflict(ctl_conflict2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2),
    .stall_timeout(stall_timeout2)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stat"},  VW'(out_stat), VW'(3'b001));
    chk({tag, "_icode"}, VW'(out_icode), VW'(4'h1));
    chk({tag, "_rA"},    VW'(out_rA), VW'(4'hF));
    chk({tag, "_rB"},    VW'(out_rB), VW'(4'hF));
    chk({tag, "_vals"},  out_vals, '0);
    chk({tag, "_cnd"},   VW'(out_cnd), '0);
    chk({tag, "_valid"}, VW'(out_valid), '0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    in_stat = 3'd0; in_icode = 4'h0; in_rA = 4'h0; in_rB = 4'h0;
    in_vals = '0; in_cnd = 1'b0;
    vals_a = '0;
    vals_a[4*WORD_W +: WORD_W] = 64'hDEAD_BEEF;
    vals_a[0 +: WORD_W] = 64'h0123_4567_89AB_CDEF;

    // Reset state
    step(2);
    chk_reset_vals("rst");
    chk("rst_scnt", VW'(stall_cnt), '0);
    chk("rst_bcnt", VW'(bubble_cnt), '0);
    chk("rst_tmo", VW'(stall_timeout), '0);
    chk("rst_conf", VW'(ctl_conflict), '0);

    // Load, 1-cycle latency
    rst = 1'b0;
    in_icode = 4'h6; in_stat = 3'd1; in_rA = 4'h2; in_rB = 4'h3; in_cnd = 1'b1;
    in_vals = vals_a;
    step(1);
    chk("ld_icode", VW'(out_icode), VW'(4'h6));
    chk("ld_stat", VW'(out_stat), VW'(3'd1));
    chk("ld_rA", VW'(out_rA), VW'(4'h2));
    chk("ld_rB", VW'(out_rB), VW'(4'h3));
    chk("ld_vals", out_vals, vals_a);
    chk("ld_cnd", VW'(out_cnd), VW'(1'b1));
    chk("ld_valid", VW'(out_valid), VW'(1'b1));

    // Stall hold with unknown upstream values
    in_icode = 4'h5;
    step(1);
    stall = 1'b1; in_icode = 4'h7; in_vals = 'x; in_rA = 'x;
    step(3);
    chk("st_icode", VW'(out_icode), VW'(4'h5));
    chk("st_valid", VW'(out_valid), VW'(1'b1));
    chk("st_vals", out_vals, vals_a);
    chk("st_rA", VW'(out_rA), VW'(4'h2));
    chk("st_scnt", VW'(stall_cnt), VW'(16'd3));
    chk("st_tmo", VW'(stall_timeout), '0);

    // Bubble with unknown upstream values
    stall = 1'b0; bubble = 1'b1; in_icode = 'x; in_stat = 'x; in_cnd = 'x;
    step(1);
    chk_reset_vals("bub");
    chk("bub_bcnt", VW'(bubble_cnt), VW'(16'd1));
    chk("bub_scnt", VW'(stall_cnt), VW'(16'd3));

    // Stall and bubble together
    bubble = 1'b0; in_icode = 4'h8; in_stat = 3'd1; in_rA = 4'h4; in_cnd = 1'b0;
    in_vals = vals_a;
    step(1);
    chk("pre_conf_valid", VW'(out_valid), VW'(1'b1));
    stall = 1'b1; bubble = 1'b1;
    step(1);
    chk_reset_vals("conf");
    chk("conf_flag", VW'(ctl_conflict), VW'(1'b1));
    chk("conf_bcnt", VW'(bubble_cnt), VW'(16'd2));
    chk("conf_scnt", VW'(stall_cnt), VW'(16'd3));
    stall = 1'b0; bubble = 1'b0;
    step(1);
    chk("conf_clear", VW'(ctl_conflict), '0);
    chk("post_conf_icode", VW'(out_icode), VW'(4'h8));

    // Watchdog: 7 stalls + free cycle does not trip; 8 consecutive does
    stall = 1'b1;
    step(7);
    chk("wd7_tmo", VW'(stall_timeout), '0);
    chk("wd7_scnt", VW'(stall_cnt), VW'(16'd10));
    chk("nar_tmo", VW'(stall_timeout2), VW'(1'b1));
    chk("nar_scnt_sat", VW'(stall_cnt2), VW'(3'd7));
    stall = 1'b0;
    step(1);
    stall = 1'b1;
    step(7);
    chk("wd_run7_tmo", VW'(stall_timeout), '0);
    step(1);
    chk("wd_run8_tmo", VW'(stall_timeout), VW'(1'b1));
    chk("wd_scnt", VW'(stall_cnt), VW'(16'd18));
    stall = 1'b0;
    step(1);
    chk("wd_sticky", VW'(stall_timeout), VW'(1'b1));
    rst = 1'b1;
    step(1);
    chk("wd_rst_tmo", VW'(stall_timeout), '0);
    chk("wd_rst_scnt", VW'(stall_cnt), '0);
    rst = 1'b0;

    // Counter saturation on the narrow instance
    bubble = 1'b1; in_icode = 'x;
    step(10);
    chk("sat_bcnt_narrow", VW'(bubble_cnt2), VW'(3'd7));
    chk("sat_bcnt_wide", VW'(bubble_cnt), VW'(16'd10));
    bubble = 1'b0;

    // Reset asserted mid-stall
    in_icode = 4'h9; in_stat = 3'd2; in_rA = 4'h1; in_rB = 4'h1; in_cnd = 1'b1;
    step(1);
    stall = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    chk_reset_vals("mid_rst");
    chk("mid_rst_scnt", VW'(stall_cnt), '0);
    chk("mid_rst_bcnt2", VW'(bubble_cnt2), '0);
    rst = 1'b0; stall = 1'b0; in_icode = 4'hA;
    step(1);
    chk("after_rst_icode", VW'(out_icode), VW'(4'hA));
    chk("after_rst_valid", VW'(out_valid), VW'(1'b1));
    chk("after_rst_scnt", VW'(stall_cnt), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_pipe_stage_reg.md
Name: y86_pipe_stage_reg

Overview:
Parametrised Y86-64 inter-stage pipeline register, the successor to the fixed execute-to-memory register. One instance serves any stage boundary (F/D, D/E, E/M, M/W). The width and count of value channels are set by parameters. It adds hazard-control inputs (stall, bubble) and a valid flag. It also keeps saturating event counters and a stall watchdog for pipeline-control debug.

Parameters:
WORD_W, 64, width of each value channel
NVAL, 5, number of value channels; packed into one bus, channel k at bits [k*WORD_W +: WORD_W]
CNT_W, 16, width of the stall and bubble event counters
MAX_STALL, 8, consecutive-stall limit that trips the watchdog (legal range 1..2^CNT_W-1)
BUB_ICODE, 4'h1, icode inserted on bubble and reset (INOP)
BUB_STAT, 3'b001, stat inserted on bubble and reset (SAOK)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold current contents
bubble  in  1  load a NOP bubble
in_stat  in  3  upstream status
in_icode  in  4  upstream instruction code
in_rA  in  4  upstream register A id
in_rB  in  4  upstream register B id
in_vals  in  NVAL*WORD_W  packed upstream values (valC, valP, valA, valB, valE order for the E/M instance)
in_cnd  in  1  upstream condition flag
out_stat  out  3  registered status
out_icode  out  4  registered icode
out_rA  out  4  registered rA
out_rB  out  4  registered rB
out_vals  out  NVAL*WORD_W  registered values
out_cnd  out  1  registered condition flag
out_valid  out  1  1 = contents came from a real upstream instruction; 0 = bubble or reset
ctl_conflict  out  1  registered; 1 for one cycle after a cycle with stall and bubble both high
stall_cnt  out  CNT_W  total stall cycles, saturating
bubble_cnt  out  CNT_W  total bubble cycles, saturating
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- All state updates on the rising edge of clk. Every output is registered; there is no combinational input-to-output path.
- Per-edge priority is rst > bubble > stall > load.
- rst: out_stat=BUB_STAT, out_icode=BUB_ICODE, out_rA=out_rB=4'hF (RNONE), out_vals=0, out_cnd=0, out_valid=0, ctl_conflict=0, both counters=0, stall run=0, stall_timeout=0. rst asserted mid-stall or mid-bubble discards that operation; the next edge without rst behaves as normal.
- bubble=1: all data fields take the reset values, out_valid=0, bubble_cnt increments.
- stall=1, bubble=0: all data fields and out_valid hold; stall_cnt increments.
- Neither asserted: every field captures its in_* value; out_valid=1. Latency is 1 cycle.
- stall=1 and bubble=1 together: bubble wins for the data fields. bubble_cnt increments and stall_cnt does not. ctl_conflict=1 on the following cycle and clears on the next edge unless the condition repeats.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Stall run counter, internal, width CNT_W:
  - increments on each edge with stall=1 and bubble=0, saturating;
  - clears to 0 on any other edge.
  - When the run reaches MAX_STALL, stall_timeout sets on that same edge and stays 1 until rst.
- Data fields are passed bit-exact; the block performs no interpretation of stat or icode.
- X on in_* during stall or bubble must not propagate to the outputs.

Test Plan:
- Reset, then load: rst=1 for 2 cycles, then in_icode=4'h6, in_stat=1, in_vals channel 4=64'hDEAD_BEEF, stall=bubble=0. After rst: out_icode=1, out_rA=F, out_valid=0, counters=0. One edge after the load: out_icode=6, out_vals[4]=DEADBEEF, out_valid=1.
- Stall hold: load icode 5, then stall=1 for 3 cycles while in_icode=7. Outputs stay icode 5, valid=1; stall_cnt=3; stall_timeout=0.
- Bubble: valid contents present, bubble=1 for 1 cycle. Outputs become icode 1, stat 1, rA=rB=F, vals 0, cnd 0, valid 0; bubble_cnt=1.
- Conflict: stall=1 and bubble=1 in one cycle. Bubble values appear, bubble_cnt+1, stall_cnt unchanged, ctl_conflict=1 for exactly 1 cycle.
- Watchdog: with MAX_STALL=8, 7 stalls then 1 free cycle gives stall_timeout=0. Then 8 consecutive stalls give stall_timeout=1, which is still 1 after stall drops. rst clears it.
- Saturation: with CNT_W=3, 10 bubbles leave bubble_cnt=7. Assert rst mid-stall: all outputs match the reset values on the next edge.
